// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external-memory responder.
// Holds default sizes, the latency ceiling and the address-width helper.
package ext_mem_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_HEIGHT    = 1 << 20;
    localparam int DEFAULT_CNT_WIDTH = 32;
    localparam int MAX_READ_LATENCY  = 8;

    typedef logic [DEFAULT_WIDTH-1:0]           word_t;
    typedef logic [$clog2(DEFAULT_HEIGHT)-1:0]  addr_t;

    // Address bits needed for a given word count (at least one bit).
    function automatic int addr_bits(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// Bus between top_chip's external-memory port and the responder.
// Handshake: no backpressure. A request is taken in every cycle its enable
// is high; a read response is a single cycle with qout_valid=1, and qout
// keeps its last delivered word while qout_valid=0.
interface ext_mem_responder_if
    import ext_mem_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDR_W    = $clog2(DEFAULT_HEIGHT),
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);

    logic                 read_en;
    logic [ADDR_W-1:0]    read_addr;
    logic [WIDTH-1:0]     qout;
    logic                 qout_valid;
    logic                 write_en;
    logic [ADDR_W-1:0]    write_addr;
    logic [WIDTH-1:0]     din;
    logic                 cnt_clear;
    logic [CNT_WIDTH-1:0] read_count;
    logic [CNT_WIDTH-1:0] write_count;
    logic                 port_conflict;
    logic                 addr_error;

    modport master (
        output read_en, read_addr, write_en, write_addr, din, cnt_clear,
        input  qout, qout_valid, read_count, write_count, port_conflict, addr_error
    );

    modport slave (
        input  read_en, read_addr, write_en, write_addr, din, cnt_clear,
        output qout, qout_valid, read_count, write_count, port_conflict, addr_error
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear wins over a same-cycle increment.
module sat_counter
    import ext_mem_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Responder for top_chip's external-memory port, living in top_system.
// Behavioural word array with fixed read latency, read-before-write on
// same-edge collisions, saturating access counters and sticky error flags.
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int HEIGHT       = DEFAULT_HEIGHT,
    parameter int READ_LATENCY = 1,
    parameter bit SINGLE_PORT  = 1'b0,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               arst_in,
    ext_mem_responder_if.slave bus
);

    localparam int AW = addr_bits(HEIGHT);
    // Latency outside 1..MAX_READ_LATENCY is clamped into range.
    localparam int RL = (READ_LATENCY < 1) ? 1 :
                        (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
    // One extra bit so HEIGHT == 2**AW still compares correctly.
    localparam logic [AW:0] HEIGHT_L = (AW + 1)'(HEIGHT);

    logic             rd_in_range;
    logic             wr_in_range;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] mem_q [HEIGHT];

    logic [RL-1:0]    vld_q;
    logic [RL-1:0]    vld_d;
    logic [WIDTH-1:0] data_q [RL];
    logic [WIDTH-1:0] data_d [RL];

    logic             port_conflict_q;
    logic             port_conflict_d;
    logic             addr_error_q;
    logic             addr_error_d;

    assign rd_in_range = ({1'b0, bus.read_addr}  < HEIGHT_L);
    assign wr_in_range = ({1'b0, bus.write_addr} < HEIGHT_L);

    // Storage has no reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (bus.write_en && wr_in_range) begin
            mem_q[bus.write_addr] <= bus.din;
        end
    end

    // Array read feeding pipeline stage 0; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[bus.read_addr];
        end
    end

    // Read pipeline advance: data moves only with a valid, so the last stage
    // (and therefore qout) holds the last delivered word during bubbles.
    always_comb begin
        vld_d     = '0;
        data_d    = data_q;
        vld_d[0]  = bus.read_en;
        if (bus.read_en) begin
            data_d[0] = rd_word;
        end
        for (int i = 1; i < RL; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Pipeline registers; reset drops every read still in flight.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            vld_q <= '0;
            for (int i = 0; i < RL; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign bus.qout       = data_q[RL-1];
    assign bus.qout_valid = vld_q[RL-1];

    // Sticky flags: cnt_clear overrides any same-cycle set.
    always_comb begin
        port_conflict_d = port_conflict_q;
        addr_error_d    = addr_error_q;
        if (bus.cnt_clear) begin
            port_conflict_d = 1'b0;
            addr_error_d    = 1'b0;
        end else begin
            if (SINGLE_PORT && bus.read_en && bus.write_en) begin
                port_conflict_d = 1'b1;
            end
            if ((bus.read_en && !rd_in_range) || (bus.write_en && !wr_in_range)) begin
                addr_error_d = 1'b1;
            end
        end
    end

    // Flag registers, asynchronously reset.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            port_conflict_q <= 1'b0;
            addr_error_q    <= 1'b0;
        end else begin
            port_conflict_q <= port_conflict_d;
            addr_error_q    <= addr_error_d;
        end
    end

    assign bus.port_conflict = port_conflict_q;
    assign bus.addr_error    = addr_error_q;

    // Every accepted access is counted, including out-of-range ones.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_read_cnt (
        .clk   (clk),
        .rst   (arst_in),
        .inc   (bus.read_en),
        .clr   (bus.cnt_clear),
        .count (bus.read_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_write_cnt (
        .clk   (clk),
        .rst   (arst_in),
        .inc   (bus.write_en),
        .clr   (bus.cnt_clear),
        .count (bus.write_count)
    );

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: two instances, one with latency 1 and
// single-port checking, one with latency 3 and 4-bit counters.
module tb_ext_mem_responder;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];

    ext_mem_responder_if #(.WIDTH(32), .ADDR_W(10), .CNT_WIDTH(32)) bus_a ();
    ext_mem_responder_if #(.WIDTH(32), .ADDR_W(10), .CNT_WIDTH(4))  bus_b ();

    ext_mem_responder #(
        .WIDTH(32), .HEIGHT(1000), .READ_LATENCY(1), .SINGLE_PORT(1'b1), .CNT_WIDTH(32)
    ) dut_a (
        .clk     (clk),
        .arst_in (rst_a),
        .bus     (bus_a)
    );

    ext_mem_responder #(
        .WIDTH(32), .HEIGHT(1000), .READ_LATENCY(3), .SINGLE_PORT(1'b0), .CNT_WIDTH(4)
    ) dut_b (
        .clk     (clk),
        .arst_in (rst_b),
        .bus     (bus_b)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drivers
    task automatic set_a(input logic re, input logic [9:0] ra, input logic we,
                         input logic [9:0] wa, input logic [31:0] d, input logic clr);
        bus_a.read_en    = re;
        bus_a.read_addr  = ra;
        bus_a.write_en   = we;
        bus_a.write_addr = wa;
        bus_a.din        = d;
        bus_a.cnt_clear  = clr;
    endtask

    task automatic set_b(input logic re, input logic [9:0] ra, input logic we,
                         input logic [9:0] wa, input logic [31:0] d, input logic clr);
        bus_b.read_en    = re;
        bus_b.read_addr  = ra;
        bus_b.write_en   = we;
        bus_b.write_addr = wa;
        bus_b.din        = d;
        bus_b.cnt_clear  = clr;
    endtask

    task automatic cyc_a(input logic re, input logic [9:0] ra, input logic we,
                         input logic [9:0] wa, input logic [31:0] d, input logic clr,
                         input logic [31:0] exp);
        @(negedge clk);
        set_a(re, ra, we, wa, d, clr);
        if (re) exp_q_a.push_back(exp);
    endtask

    task automatic cyc_b(input logic re, input logic [9:0] ra, input logic we,
                         input logic [9:0] wa, input logic [31:0] d, input logic clr,
                         input logic [31:0] exp);
        @(negedge clk);
        set_b(re, ra, we, wa, d, clr);
        if (re) exp_q_b.push_back(exp);
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) cyc_a(1'b0, 10'd0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic idle_b(input int n);
        for (int i = 0; i < n; i++) cyc_b(1'b0, 10'd0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Scoreboard monitor for instance A
    always @(negedge clk) begin
        if (!rst_a && bus_a.qout_valid) begin
            if (exp_q_a.size() == 0) begin
                check("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("a_qout", bus_a.qout, exp_q_a.pop_front());
            end
        end
    end

    // Scoreboard monitor for instance B
    always @(negedge clk) begin
        if (!rst_b && bus_b.qout_valid) begin
            if (exp_q_b.size() == 0) begin
                check("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("b_qout", bus_b.qout, exp_q_b.pop_front());
            end
        end
    end

    // Directed stimulus
    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_a(1'b0, 10'd0, 1'b0, 10'd0, 32'd0, 1'b0);
        set_b(1'b0, 10'd0, 1'b0, 10'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);

        check("a_rst_qout",   bus_a.qout, 32'd0);
        check("a_rst_valid",  32'(bus_a.qout_valid), 32'd0);
        check("a_rst_rcnt",   bus_a.read_count, 32'd0);
        check("a_rst_wcnt",   bus_a.write_count, 32'd0);
        check("a_rst_pc",     32'(bus_a.port_conflict), 32'd0);
        check("a_rst_ae",     32'(bus_a.addr_error), 32'd0);
        check("b_rst_qout",   bus_b.qout, 32'd0);
        check("b_rst_valid",  32'(bus_b.qout_valid), 32'd0);
        check("b_rst_rcnt",   32'(bus_b.read_count), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // A: write then read one cycle later, latency 1
        cyc_a(1'b0, 10'd0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 32'd0);
        cyc_a(1'b1, 10'd5, 1'b0, 10'd0, 32'd0, 1'b0, 32'hDEADBEEF);
        idle_a(1);
        check("a_rcnt_1", bus_a.read_count, 32'd1);
        check("a_wcnt_1", bus_a.write_count, 32'd1);
        check("a_pc_0",   32'(bus_a.port_conflict), 32'd0);

        // A: same-cycle read/write to 9 returns old data, raises conflict
        cyc_a(1'b0, 10'd0, 1'b1, 10'd9, 32'd3, 1'b0, 32'd0);
        cyc_a(1'b1, 10'd9, 1'b1, 10'd9, 32'd7, 1'b0, 32'd3);
        cyc_a(1'b1, 10'd9, 1'b0, 10'd0, 32'd0, 1'b0, 32'd7);
        idle_a(1);
        check("a_pc_set",  32'(bus_a.port_conflict), 32'd1);
        check("a_rcnt_3",  bus_a.read_count, 32'd3);
        check("a_wcnt_3",  bus_a.write_count, 32'd3);
        idle_a(3);
        check("a_pc_sticky", 32'(bus_a.port_conflict), 32'd1);

        // A: clear beats same-cycle counts and conflict; accesses still serviced
        cyc_a(1'b1, 10'd5, 1'b1, 10'd20, 32'h55, 1'b1, 32'hDEADBEEF);
        idle_a(1);
        check("a_clr_rcnt", bus_a.read_count, 32'd0);
        check("a_clr_wcnt", bus_a.write_count, 32'd0);
        check("a_clr_pc",   32'(bus_a.port_conflict), 32'd0);
        cyc_a(1'b1, 10'd20, 1'b0, 10'd0, 32'd0, 1'b0, 32'h55);

        // A: last legal address
        cyc_a(1'b0, 10'd0, 1'b1, 10'd999, 32'h999, 1'b0, 32'd0);
        cyc_a(1'b1, 10'd999, 1'b0, 10'd0, 32'd0, 1'b0, 32'h999);
        idle_a(1);
        check("a_ae_edge",  32'(bus_a.addr_error), 32'd0);
        check("a_rcnt_2",   bus_a.read_count, 32'd2);
        check("a_wcnt_1b",  bus_a.write_count, 32'd1);

        // A: out of range write dropped, read returns 0, both counted
        cyc_a(1'b0, 10'd0, 1'b1, 10'd1000, 32'hBAD, 1'b0, 32'd0);
        cyc_a(1'b1, 10'd1000, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0);
        cyc_a(1'b1, 10'd5, 1'b0, 10'd0, 32'd0, 1'b0, 32'hDEADBEEF);
        idle_a(1);
        check("a_ae_set",  32'(bus_a.addr_error), 32'd1);
        check("a_rcnt_4",  bus_a.read_count, 32'd4);
        check("a_wcnt_2",  bus_a.write_count, 32'd2);
        idle_a(1);
        check("a_hold_qout",  bus_a.qout, 32'hDEADBEEF);
        check("a_hold_valid", 32'(bus_a.qout_valid), 32'd0);

        // B: preload, then three back-to-back reads at latency 3
        cyc_b(1'b0, 10'd0, 1'b1, 10'd0, 32'd10, 1'b0, 32'd0);
        cyc_b(1'b0, 10'd0, 1'b1, 10'd1, 32'd11, 1'b0, 32'd0);
        cyc_b(1'b0, 10'd0, 1'b1, 10'd2, 32'd12, 1'b0, 32'd0);
        cyc_b(1'b1, 10'd0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd10);
        cyc_b(1'b1, 10'd1, 1'b0, 10'd0, 32'd0, 1'b0, 32'd11);
        cyc_b(1'b1, 10'd2, 1'b0, 10'd0, 32'd0, 1'b0, 32'd12);
        idle_b(5);
        check("b_hold_qout",  bus_b.qout, 32'd12);
        check("b_hold_valid", 32'(bus_b.qout_valid), 32'd0);
        check("b_rcnt_3",     32'(bus_b.read_count), 32'd3);
        check("b_wcnt_3",     32'(bus_b.write_count), 32'd3);

        // B: dual-port same-cycle access, no conflict flag
        cyc_b(1'b1, 10'd0, 1'b1, 10'd0, 32'd99, 1'b0, 32'd10);
        cyc_b(1'b1, 10'd0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd99);
        idle_b(5);
        check("b_pc_0",   32'(bus_b.port_conflict), 32'd0);
        check("b_rcnt_5", 32'(bus_b.read_count), 32'd5);
        check("b_wcnt_4", 32'(bus_b.write_count), 32'd4);

        // B: 20 more reads saturate the 4-bit read counter at 15
        for (int i = 0; i < 20; i++) cyc_b(1'b1, 10'd1, 1'b0, 10'd0, 32'd0, 1'b0, 32'd11);
        idle_b(5);
        check("b_rcnt_sat", 32'(bus_b.read_count), 32'd15);
        check("b_wcnt_4b",  32'(bus_b.write_count), 32'd4);

        // B: reset with two reads in flight drops them
        @(negedge clk);
        set_b(1'b1, 10'd2, 1'b0, 10'd0, 32'd0, 1'b0);
        @(negedge clk);
        set_b(1'b1, 10'd2, 1'b0, 10'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        set_b(1'b0, 10'd0, 1'b0, 10'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        idle_b(6);
        check("b_arst_valid", 32'(bus_b.qout_valid), 32'd0);
        check("b_arst_qout",  bus_b.qout, 32'd0);
        check("b_arst_rcnt",  32'(bus_b.read_count), 32'd0);
        check("b_arst_wcnt",  32'(bus_b.write_count), 32'd0);

        // B: array survives reset
        cyc_b(1'b1, 10'd1, 1'b0, 10'd0, 32'd0, 1'b0, 32'd11);
        idle_b(5);
        check("b_rcnt_post", 32'(bus_b.read_count), 32'd1);

        idle_a(2);
        check("a_all_delivered", 32'(exp_q_a.size()), 32'd0);
        check("b_all_delivered", 32'(exp_q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
